booth_mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one Booth multiplier datapath among N_REQ requesters. Accepts one request at a time and latches its operands. Pulses the multiplier start, waits for done (with a watchdog), and returns the product to the granted requester. Clears the multiplier back to idle between operations. Sits between client blocks and the Booth multiplier's start/done/operand interface.

---
 rtl/booth_mul_arbiter.sv | 130 +++++++++++++
 tb/tb_booth_mul_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one Booth multiplier among N_REQ requesters.
// One operation in flight: IDLE -> START -> WAIT (watchdog) -> RESP -> IDLE.
module booth_mul_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 4 * WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [2*WIDTH-1:0]       rsp_prod,
    output logic                     rsp_err,
    output logic                     busy,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic                     mul_rst,
    input  logic                     mul_done,
    input  logic [2*WIDTH-1:0]       mul_prod
);

    localparam int unsigned GW   = $clog2(N_REQ);
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t            state;
    logic [GW-1:0]     gnt;
    logic [GW-1:0]     ptr;
    logic [WD_W-1:0]   wd;
    logic              mul_rst_q;

    logic              found_c;
    logic [GW-1:0]     pick_c;
    logic [GW-1:0]     idx_c;
    logic [WIDTH-1:0]  a_c;
    logic [WIDTH-1:0]  b_c;

    // First requesting index at or after ptr, wrapping, plus its operands.
    always_comb begin
        found_c = 1'b0;
        pick_c  = '0;
        idx_c   = '0;
        a_c     = '0;
        b_c     = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            idx_c = GW'((32'(ptr) + off) % N_REQ);
            if (!found_c && req_valid[idx_c]) begin
                found_c = 1'b1;
                pick_c  = idx_c;
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_c == GW'(i)) begin
                a_c = req_a[i*WIDTH +: WIDTH];
                b_c = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            ptr       <= '0;
            wd        <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_prod  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_rst_q <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            req_ready <= '0;
            rsp_valid <= '0;
            mul_rst_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (found_c) begin
                        gnt       <= pick_c;
                        mul_a     <= a_c;
                        mul_b     <= b_c;
                        wd        <= '0;
                        busy      <= 1'b1;
                        mul_start <= 1'b1;
                        req_ready <= N_REQ'(1) << pick_c;
                        state     <= START;
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    // Completion takes priority over a coincident watchdog expiry.
                    if (mul_done) begin
                        rsp_prod  <= mul_prod;
                        rsp_err   <= 1'b0;
                        rsp_valid <= N_REQ'(1) << gnt;
                        mul_rst_q <= 1'b1;
                        state     <= RESP;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        rsp_prod  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= N_REQ'(1) << gnt;
                        mul_rst_q <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                RESP: begin
                    ptr   <= (gnt == GW'(N_REQ - 1)) ? '0 : gnt + 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Multiplier clear also follows the arbiter's own reset immediately.
    assign mul_rst = mul_rst_q | rst;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Randomized self-checking bench for booth_mul_arbiter with a behavioural
// multiplier model and a round-robin / latency reference model.
module tb_booth_mul_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned TO = 32;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     rsp_valid;
    logic [2*W-1:0]   rsp_prod;
    logic             rsp_err;
    logic             busy;
    logic             mul_start;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic             mul_rst;
    logic             mul_done;
    logic [2*W-1:0]   mul_prod;

    booth_mul_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_prod(rsp_prod),
        .rsp_err(rsp_err), .busy(busy), .mul_start(mul_start), .mul_a(mul_a),
        .mul_b(mul_b), .mul_rst(mul_rst), .mul_done(mul_done), .mul_prod(mul_prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int mlat    = 2;      // WAIT cycle in which done is first seen; 0 = never
    int mcnt    = 0;
    int n_start = 0;
    int start_cyc = 0;
    int rsp_cyc   = 0;
    int m_ptr     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier: sticky done after mlat WAIT cycles, cleared by mul_rst.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_done <= 1'b0;
            mcnt     <= 0;
        end else if (mul_rst) begin
            mul_done <= 1'b0;
            mcnt     <= 0;
        end else if (mul_start) begin
            if (mlat == 1) mul_done <= 1'b1;
            else if (mlat > 1) mcnt <= mlat - 1;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) mul_done <= 1'b1;
        end
    end
    assign mul_prod = 16'($signed(mul_a)) * 16'($signed(mul_b));

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [2*W-1:0] ref_prod(input int r);
        logic signed [W-1:0] a, b;
        a = req_a[r*W +: W];
        b = req_b[r*W +: W];
        return 16'(a) * 16'(b);
    endfunction

    task automatic set_ops(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
    endtask

    // Advance on negedges until a response pulse, logging starts and ready pulses.
    task automatic run_until_rsp(input int bound, input bit drop,
                                 output logic [N-1:0] vec, output logic [2*W-1:0] prod,
                                 output logic err, output logic mrst,
                                 output int rdy_cnt, output logic [N-1:0] rdy_vec,
                                 output bit got);
        got = 0; vec = '0; prod = '0; err = 1'b0; mrst = 1'b0; rdy_cnt = 0; rdy_vec = '0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            if (mul_start) begin n_start++; start_cyc = cyc; end
            if (req_ready != '0) begin rdy_cnt++; rdy_vec = req_ready; end
            if (drop) req_valid = req_valid & ~req_ready;
            if (rsp_valid != '0) begin
                got = 1; vec = rsp_valid; prod = rsp_prod; err = rsp_err;
                mrst = mul_rst; rsp_cyc = cyc;
            end
        end
    endtask

    logic [N-1:0]   vec, rdy_vec;
    logic [2*W-1:0] prod, exp_p;
    logic           err, mrst;
    int             rdy_cnt, g;
    bit             got;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({req_ready, rsp_valid, busy, mul_start, mul_a, mul_b, rsp_prod, rsp_err} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0",
                {req_ready, rsp_valid, busy, mul_start, mul_a, mul_b, rsp_prod, rsp_err});
        end
        n_tests++;
        if (mul_rst !== 1'b1) begin n_fail++; $display("FAIL reset_mul_rst: got %b want 1", mul_rst); end
        rst = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        n_tests++;
        if (mul_rst !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL post_reset: mul_rst=%b busy=%b want 0 0", mul_rst, busy);
        end
    endtask

    task automatic test_pair();
        int prev_rsp;
        mlat = 3;
        set_ops(1, W'($urandom), W'($urandom));
        set_ops(3, W'($urandom), W'($urandom));
        req_valid = 4'b1010;
        for (int op = 0; op < 2; op++) begin
            g = rr_pick(req_valid, m_ptr);
            exp_p = ref_prod(g);
            prev_rsp = rsp_cyc;
            run_until_rsp(40, 1'b1, vec, prod, err, mrst, rdy_cnt, rdy_vec, got);
            n_tests++;
            if (!got || vec !== N'(1 << g) || prod !== exp_p || rdy_vec !== N'(1 << g)) begin
                n_fail++; $display("FAIL pair_op%0d: got=%0d vec=%b prod=%h rdy=%b want vec=%b prod=%h",
                    op, got, vec, prod, rdy_vec, N'(1 << g), exp_p);
            end
            n_tests++;
            if (op == 1 && start_cyc <= prev_rsp) begin
                n_fail++; $display("FAIL pair_overlap: start %0d not after rsp %0d", start_cyc, prev_rsp);
            end
            m_ptr = (g + 1) % N;
        end
        n_tests++;
        if (g !== 3) begin n_fail++; $display("FAIL pair_order: last grant %0d want 3", g); end
    endtask

    task automatic test_single();
        mlat = 9;
        set_ops(2, 8'hFD, 8'h05);
        @(negedge clk);
        req_valid = 4'b0100;
        run_until_rsp(40, 1'b1, vec, prod, err, mrst, rdy_cnt, rdy_vec, got);
        n_tests++;
        if (!got || vec !== 4'b0100 || prod !== 16'hFFF1 || err !== 1'b0) begin
            n_fail++; $display("FAIL single_rsp: got=%0d vec=%b prod=%h err=%b want 0100 fff1 0",
                got, vec, prod, err);
        end
        n_tests++;
        if (rdy_cnt !== 1 || rdy_vec !== 4'b0100) begin
            n_fail++; $display("FAIL single_ready: count=%0d vec=%b want 1 0100", rdy_cnt, rdy_vec);
        end
        n_tests++;
        if (mrst !== 1'b1) begin n_fail++; $display("FAIL single_mul_rst: got %b want 1", mrst); end
        n_tests++;
        if (rsp_cyc - start_cyc !== 10) begin
            n_fail++; $display("FAIL single_latency: got %0d want 10", rsp_cyc - start_cyc);
        end
        m_ptr = 3;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_all_four();
        int s0, lat, prev_rsp;
        do_reset();
        for (int r = 0; r < N; r++) set_ops(r, W'($urandom), W'($urandom));
        s0 = n_start;
        req_valid = '1;
        for (int op = 0; op < 8; op++) begin
            lat = int'($urandom_range(1, 6));
            mlat = lat;
            g = rr_pick(req_valid, m_ptr);
            exp_p = ref_prod(g);
            prev_rsp = rsp_cyc;
            run_until_rsp(40, 1'b0, vec, prod, err, mrst, rdy_cnt, rdy_vec, got);
            n_tests++;
            if (!got || vec !== N'(1 << g) || g !== op % 4 || prod !== exp_p || err !== 1'b0) begin
                n_fail++; $display("FAIL rr_op%0d: got=%0d vec=%b prod=%h err=%b want grant %0d prod=%h",
                    op, got, vec, prod, err, op % 4, exp_p);
            end
            n_tests++;
            if (rsp_cyc - start_cyc !== lat + 1) begin
                n_fail++; $display("FAIL rr_latency%0d: got %0d want %0d", op, rsp_cyc - start_cyc, lat + 1);
            end
            if (op > 0) begin
                n_tests++;
                if (start_cyc - prev_rsp !== 2) begin
                    n_fail++; $display("FAIL rr_gap%0d: start-rsp %0d want 2", op, start_cyc - prev_rsp);
                end
            end
            m_ptr = (g + 1) % N;
        end
        req_valid = '0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (n_start - s0 !== 8 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rr_starts: count=%0d busy=%b want 8 0", n_start - s0, busy);
        end
    endtask

    task automatic test_timeout();
        int r;
        r = int'($urandom_range(0, N - 1));
        set_ops(r, W'($urandom), W'($urandom));
        mlat = 0;
        req_valid = N'(1 << r);
        run_until_rsp(100, 1'b1, vec, prod, err, mrst, rdy_cnt, rdy_vec, got);
        n_tests++;
        if (!got || vec !== N'(1 << r) || prod !== '0 || err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_rsp: got=%0d vec=%b prod=%h err=%b want %b 0000 1",
                got, vec, prod, err, N'(1 << r));
        end
        n_tests++;
        if (rsp_cyc - start_cyc !== TO + 1) begin
            n_fail++; $display("FAIL timeout_latency: got %0d want %0d", rsp_cyc - start_cyc, TO + 1);
        end
        m_ptr = (r + 1) % N;
        r = (r + 2) % N;
        set_ops(r, W'($urandom), W'($urandom));
        exp_p = ref_prod(r);
        mlat = 4;
        req_valid = N'(1 << r);
        run_until_rsp(40, 1'b1, vec, prod, err, mrst, rdy_cnt, rdy_vec, got);
        n_tests++;
        if (!got || vec !== N'(1 << r) || prod !== exp_p || err !== 1'b0) begin
            n_fail++; $display("FAIL after_timeout: got=%0d vec=%b prod=%h err=%b want %b %h 0",
                got, vec, prod, err, N'(1 << r), exp_p);
        end
        m_ptr = (r + 1) % N;
    endtask

    task automatic test_same_cycle();
        int r;
        r = m_ptr;
        set_ops(r, W'($urandom_range(1, 255)), W'($urandom_range(1, 255)));
        exp_p = ref_prod(r);
        mlat = TO;
        req_valid = N'(1 << r);
        run_until_rsp(100, 1'b1, vec, prod, err, mrst, rdy_cnt, rdy_vec, got);
        n_tests++;
        if (!got || prod !== exp_p || err !== 1'b0 || rsp_cyc - start_cyc !== TO + 1) begin
            n_fail++; $display("FAIL done_vs_timeout: got=%0d prod=%h err=%b lat=%0d want %h 0 %0d",
                got, prod, err, rsp_cyc - start_cyc, exp_p, TO + 1);
        end
        m_ptr = (r + 1) % N;
    endtask

    task automatic test_reset_mid_wait();
        int seen_rsp, waited;
        set_ops(0, W'($urandom), W'($urandom));
        mlat = 2;
        req_valid = 4'b0001;
        run_until_rsp(40, 1'b1, vec, prod, err, mrst, rdy_cnt, rdy_vec, got);
        n_tests++;
        if (!got || vec !== 4'b0001) begin
            n_fail++; $display("FAIL mid_pre_op: got=%0d vec=%b want 0001", got, vec);
        end
        mlat = 0;
        req_valid = 4'b0100;
        waited = 0;
        while (!mul_start && waited < 10) begin @(negedge clk); waited++; end
        n_tests++;
        if (!mul_start) begin n_fail++; $display("FAIL mid_start: mul_start=%b want 1", mul_start); end
        req_valid = '0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        seen_rsp = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if ({req_ready, rsp_valid, busy, mul_start, mul_a, mul_b, rsp_prod, rsp_err} !== '0
                || mul_rst !== 1'b1) begin
                n_fail++; $display("FAIL mid_reset_outputs%0d: got %h mul_rst=%b want 0 1", i,
                    {req_ready, rsp_valid, busy, mul_start, mul_a, mul_b, rsp_prod, rsp_err}, mul_rst);
            end
        end
        rst = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid != '0 || busy) seen_rsp++;
        end
        n_tests++;
        if (seen_rsp !== 0) begin
            n_fail++; $display("FAIL mid_dropped: %0d active cycles after reset want 0", seen_rsp);
        end
        mlat = 2;
        for (int r = 0; r < N; r++) set_ops(r, W'($urandom), W'($urandom));
        exp_p = ref_prod(0);
        req_valid = '1;
        run_until_rsp(40, 1'b1, vec, prod, err, mrst, rdy_cnt, rdy_vec, got);
        req_valid = '0;
        n_tests++;
        if (!got || vec !== 4'b0001 || prod !== exp_p) begin
            n_fail++; $display("FAIL mid_regrant: got=%0d vec=%b prod=%h want 0001 %h", got, vec, prod, exp_p);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        test_reset();
        test_pair();
        test_single();
        test_all_four();
        test_timeout();
        test_same_cycle();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
